// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
//  Package     : mips_defs
//  Description : Shared constants and types for the MIPS pipeline control
//                unit: stall-vector layout, stall patterns, exception vector
//                and the pipe_ctrl state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_defs;

  localparam int STALL_W = 6;
  localparam int CNT_W   = 6;

  // Bit positions inside the stall vector
  localparam int STL_PC = 0;
  localparam int STL_IF = 1;
  localparam int STL_ID = 2;
  localparam int STL_EX = 3;
  localparam int STL_WB = 4;

  // Stall patterns: holding PC..ID bubbles EX, holding PC..EX bubbles MEM
  localparam logic [STALL_W-1:0] STALL_NONE  = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_LDUSE = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_MD    = 6'b001111;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } pc_state_e;

  // Countdown start value: the request cycle itself is the first stall cycle
  function automatic logic [CNT_W-1:0] md_load_val(input logic is_div,
                                                   input int   mult_cycles,
                                                   input int   div_cycles);
    return is_div ? CNT_W'(div_cycles - 1) : CNT_W'(mult_cycles - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_md_timer.sv
`default_nettype none
// ============================================================================
//  Module      : md_timer
//  Description : Loadable 6-bit down-counter tracking remaining MULT/DIV
//                occupancy of EX. Clear beats load beats decrement; the
//                count never wraps below zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_timer
  import mips_defs::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             zero
);

  logic [CNT_W-1:0] r_cnt;

  // Countdown register, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign zero = (r_cnt == '0);
  assign busy = ~zero;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Pipeline hold/flush controller for the five-stage MIPS core.
//                Load-use hazard detection, MULT/DIV EX occupancy sequencing
//                and MEM-stage exception flush.
//                Optional macro PIPE_CTRL_PERF_EN adds saturating stall and
//                flush cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import mips_defs::*;
#(
  parameter int          MULT_CYCLES = 4,
  parameter int          DIV_CYCLES  = 34,
  parameter logic [31:0] EXC_VECTOR  = mips_defs::EXC_VECTOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs_addr,
  input  logic [4:0]         id_rt_addr,
  input  logic               id_rs_rd,
  input  logic               id_rt_rd,
  input  logic               ex_is_load,
  input  logic [4:0]         ex_wd_addr,
  input  logic               ex_md_req,
  input  logic               ex_md_div,
  input  logic               mem_excp,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               md_done
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  pc_state_e          r_state;
  pc_state_e          w_state_nxt;
  logic [STALL_W-1:0] w_stall;
  logic               w_flush;
  logic               w_load;
  logic               w_dec;
  logic               w_clr;
  logic               w_load_use;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_busy;
  logic               w_zero;

  // $0 is hard-wired, so a load targeting it can never create a hazard
  assign w_load_use = ex_is_load && (ex_wd_addr != 5'd0) &&
                      ((id_rs_rd && (id_rs_addr == ex_wd_addr)) ||
                       (id_rt_rd && (id_rt_addr == ex_wd_addr)));

  md_timer u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (md_load_val(ex_md_div, MULT_CYCLES, DIV_CYCLES)),
    .dec      (w_dec),
    .clr      (w_clr),
    .cnt      (w_cnt),
    .busy     (w_busy),
    .zero     (w_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and hold/flush decode; exception > MULT/DIV > load-use
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = STALL_NONE;
    w_flush     = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_excp) begin
          w_flush = 1'b1;
        end else if (ex_md_req) begin
          w_stall     = STALL_MD;
          w_load      = 1'b1;
          w_state_nxt = ST_MD_BUSY;
        end else if (w_load_use) begin
          w_stall = STALL_LDUSE;
        end
      end
      ST_MD_BUSY: begin
        if (mem_excp) begin
          w_flush     = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (w_busy) begin
          w_stall = STALL_MD;
          w_dec   = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Combinational outputs are forced quiet while reset is held
  assign stall   = rst ? w_stall : STALL_NONE;
  assign flush   = rst & w_flush;
  assign new_pc  = flush ? EXC_VECTOR : 32'h0000_0000;
  // Registered-state only: last MD_BUSY cycle with the countdown expired
  assign md_done = (r_state == ST_MD_BUSY) && w_zero;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating event counters for stall and flush cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if ((stall != STALL_NONE) && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  // Performance counters not built
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Scoreboard bench for pipe_ctrl. The driver pushes the
//                hand-computed response for each cycle; a negedge monitor
//                pops and compares. Build with PIPE_CTRL_PERF_EN to also
//                cover the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam logic [31:0] C_EXC = 32'hBFC0_0380;
  localparam logic [5:0]  C_MD  = 6'b001111;
  localparam logic [5:0]  C_LU  = 6'b000111;
  localparam logic [5:0]  C_NO  = 6'b000000;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs_addr;
  logic [4:0]  id_rt_addr;
  logic        id_rs_rd;
  logic        id_rt_rd;
  logic        ex_is_load;
  logic [4:0]  ex_wd_addr;
  logic        ex_md_req;
  logic        ex_md_div;
  logic        mem_excp;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        md_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        md_done;
    logic        chk_perf;
    logic [31:0] p_stall;
    logic [31:0] p_flush;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pipe_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .id_rs_rd   (id_rs_rd),
    .id_rt_rd   (id_rt_rd),
    .ex_is_load (ex_is_load),
    .ex_wd_addr (ex_wd_addr),
    .ex_md_req  (ex_md_req),
    .ex_md_div  (ex_md_div),
    .mem_excp   (mem_excp),
    .stall      (stall),
    .flush      (flush),
    .new_pc     (new_pc),
    .md_done    (md_done)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and return all data inputs to idle
  task automatic tick();
    @(posedge clk);
    #1;
    id_rs_addr = '0; id_rt_addr = '0; id_rs_rd = 1'b0; id_rt_rd = 1'b0;
    ex_is_load = 1'b0; ex_wd_addr = '0; ex_md_req = 1'b0; ex_md_div = 1'b0;
    mem_excp   = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [5:0] s,
                            input logic f, input logic d);
    exp_t e;
    e.name = nm; e.stall = s; e.flush = f; e.new_pc = f ? C_EXC : 32'h0;
    e.md_done = d; e.chk_perf = 1'b0; e.p_stall = '0; e.p_flush = '0;
    sb.push_back(e);
  endtask

  task automatic expect_perf(input string nm, input logic [31:0] ps,
                             input logic [31:0] pf);
    exp_t e;
    e.name = nm; e.stall = C_NO; e.flush = 1'b0; e.new_pc = 32'h0;
    e.md_done = 1'b0; e.chk_perf = 1'b1; e.p_stall = ps; e.p_flush = pf;
    sb.push_back(e);
  endtask

  // EX holds "lw $<r>", ID reads $<r> through rs
  task automatic set_load_use(input logic [4:0] r);
    ex_is_load = 1'b1; ex_wd_addr = r; id_rs_addr = r; id_rs_rd = 1'b1;
  endtask

  // Monitor: one response is presented every cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_tests++;
      if ({stall, flush, new_pc, md_done} !== {e.stall, e.flush, e.new_pc, e.md_done}) begin
        n_fail++;
        $display("FAIL %s: got stall=%b flush=%b new_pc=%h md_done=%b, want stall=%b flush=%b new_pc=%h md_done=%b",
                 e.name, stall, flush, new_pc, md_done, e.stall, e.flush, e.new_pc, e.md_done);
      end
`ifdef PIPE_CTRL_PERF_EN
      if (e.chk_perf) begin
        n_tests++;
        if ({perf_stall_cnt, perf_flush_cnt} !== {e.p_stall, e.p_flush}) begin
          n_fail++;
          $display("FAIL %s: got perf_stall=%0d perf_flush=%0d, want perf_stall=%0d perf_flush=%0d",
                   e.name, perf_stall_cnt, perf_flush_cnt, e.p_stall, e.p_flush);
        end
      end
`endif
    end
  end

  initial begin
    rst = 1'b0;
    id_rs_addr = '0; id_rt_addr = '0; id_rs_rd = 1'b0; id_rt_rd = 1'b0;
    ex_is_load = 1'b0; ex_wd_addr = '0; ex_md_req = 1'b0; ex_md_div = 1'b0;
    mem_excp   = 1'b0;

    // Reset holds every output low even with active requests
    tick(); ex_md_req = 1'b1; mem_excp = 1'b1; expect_out("reset_a", C_NO, 1'b0, 1'b0);
    tick(); ex_md_req = 1'b1; set_load_use(5'd3); expect_out("reset_b", C_NO, 1'b0, 1'b0);
    tick(); rst = 1'b1; expect_out("idle", C_NO, 1'b0, 1'b0);

    // Load-use through rs, then the load has left EX
    tick(); set_load_use(5'd5); expect_out("lduse_rs", C_LU, 1'b0, 1'b0);
    tick(); id_rs_addr = 5'd5; id_rs_rd = 1'b1; expect_out("lduse_after", C_NO, 1'b0, 1'b0);
    // Load-use through rt
    tick(); ex_is_load = 1'b1; ex_wd_addr = 5'd9; id_rt_addr = 5'd9; id_rt_rd = 1'b1;
    expect_out("lduse_rt", C_LU, 1'b0, 1'b0);
    // Address match but the field is not read
    tick(); ex_is_load = 1'b1; ex_wd_addr = 5'd7; id_rs_addr = 5'd7;
    expect_out("lduse_noread", C_NO, 1'b0, 1'b0);
    // Load to $0 never hazards
    tick(); set_load_use(5'd0); expect_out("lduse_r0", C_NO, 1'b0, 1'b0);

    // MULT, 4 cycles; request held and load-use ignored while busy
    tick(); ex_md_req = 1'b1; expect_out("mult_c0", C_MD, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick(); ex_md_req = 1'b1;
      if (i == 2) set_load_use(5'd4);
      expect_out($sformatf("mult_c%0d", i), C_MD, 1'b0, 1'b0);
    end
    tick(); expect_out("mult_done", C_NO, 1'b0, 1'b1);
    tick(); expect_out("mult_idle", C_NO, 1'b0, 1'b0);

    // DIV with a simultaneous load-use: MULT/DIV wins, 34 cycles
    tick(); ex_md_req = 1'b1; ex_md_div = 1'b1; set_load_use(5'd6);
    expect_out("div_c0", C_MD, 1'b0, 1'b0);
    for (int i = 1; i < 34; i++) begin
      tick(); expect_out($sformatf("div_c%0d", i), C_MD, 1'b0, 1'b0);
    end
    tick(); expect_out("div_done", C_NO, 1'b0, 1'b1);
    tick(); expect_out("div_idle", C_NO, 1'b0, 1'b0);

    // DIV interrupted by an exception at cycle 10
    tick(); ex_md_req = 1'b1; ex_md_div = 1'b1; expect_out("dive_c0", C_MD, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick(); expect_out($sformatf("dive_c%0d", i), C_MD, 1'b0, 1'b0);
    end
    tick(); mem_excp = 1'b1; expect_out("dive_flush", C_NO, 1'b1, 1'b0);
    tick(); set_load_use(5'd8); expect_out("dive_run_lduse", C_LU, 1'b0, 1'b0);
    tick(); expect_out("dive_nodone_a", C_NO, 1'b0, 1'b0);
    tick(); expect_out("dive_nodone_b", C_NO, 1'b0, 1'b0);

    // Exception in RUN outranks MULT request and load-use
    tick(); mem_excp = 1'b1; ex_md_req = 1'b1; set_load_use(5'd2);
    expect_out("run_excp", C_NO, 1'b1, 1'b0);
    tick(); expect_out("run_excp_after", C_NO, 1'b0, 1'b0);

    // Reset in the middle of MD_BUSY, then a full restart
    tick(); ex_md_req = 1'b1; expect_out("rmid_c0", C_MD, 1'b0, 1'b0);
    tick(); expect_out("rmid_c1", C_MD, 1'b0, 1'b0);
    tick(); rst = 1'b0; ex_md_req = 1'b1; expect_out("rmid_reset", C_NO, 1'b0, 1'b0);
    tick(); rst = 1'b1; ex_md_req = 1'b1; expect_out("rmid_r0", C_MD, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick(); expect_out($sformatf("rmid_r%0d", i), C_MD, 1'b0, 1'b0);
    end
    tick(); expect_out("rmid_done", C_NO, 1'b0, 1'b1);
    tick(); expect_out("rmid_idle", C_NO, 1'b0, 1'b0);

`ifdef PIPE_CTRL_PERF_EN
    // Fresh counters: MULT(4) + one load-use + one flush
    tick(); rst = 1'b0; expect_out("perf_reset", C_NO, 1'b0, 1'b0);
    tick(); rst = 1'b1; ex_md_req = 1'b1; expect_out("perf_m0", C_MD, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick(); expect_out($sformatf("perf_m%0d", i), C_MD, 1'b0, 1'b0);
    end
    tick(); expect_out("perf_mdone", C_NO, 1'b0, 1'b1);
    tick(); set_load_use(5'd12); expect_out("perf_lduse", C_LU, 1'b0, 1'b0);
    tick(); mem_excp = 1'b1; expect_out("perf_flush", C_NO, 1'b1, 1'b0);
    tick(); expect_perf("perf_counts", 32'd5, 32'd1);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core: the single source of per-stage hold (stall) and flush for PC, IF_ID, ID_EX, EX_MEM and MEM_WB. Detects load-use hazards between ID and EX, sequences multi-cycle MULT/DIV occupancy of EX with an internal countdown, and flushes the pipe on a MEM-stage exception. Sits beside the datapath at the top level and drives every pipeline register's hold/clear inputs.

## Interface
- MULT_CYCLES, 4, EX occupancy for MULT/MULTU; legal range 1..63
- DIV_CYCLES, 34, EX occupancy for DIV/DIVU; legal range 1..63
- EXC_VECTOR, 32'hBFC0_0380, PC loaded on exception flush
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs_addr  in  5  rs index of instruction in ID
- id_rt_addr  in  5  rt index of instruction in ID
- id_rs_rd  in  1  ID instruction reads rs
- id_rt_rd  in  1  ID instruction reads rt
- ex_is_load  in  1  EX instruction is a load
- ex_wd_addr  in  5  EX destination register
- ex_md_req  in  1  EX holds a MULT/DIV-class instruction
- ex_md_div  in  1  1 = divide, 0 = multiply; sampled with ex_md_req
- mem_excp  in  1  exception raised in MEM
- stall  out  6  hold vector; bit0 PC, bit1 IF_ID, bit2 ID_EX, bit3 EX_MEM, bit4 MEM_WB, bit5 reserved (always 0)
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  EXC_VECTOR while flush=1, else 0
- md_done  out  1  one-cycle pulse: MULT/DIV result valid, EX may advance

## Operation
- Stall semantics: stall[i]=1 holds stage i; stall[i]=1 with stall[i+1]=0 inserts a bubble into stage i+1.
- States: RUN, MD_BUSY. 6-bit counter cnt.
- RUN:
  - mem_excp → flush=1, stall=0, stay RUN.
  - else ex_md_req → stall=6'b001111, cnt←(ex_md_div ? DIV_CYCLES : MULT_CYCLES)−1, go MD_BUSY.
  - else load-use (ex_is_load & ex_wd_addr≠0 & ((id_rs_rd & id_rs_addr==ex_wd_addr) | (id_rt_rd & id_rt_addr==ex_wd_addr))) → stall=6'b000111.
  - else stall=0.
- MD_BUSY:
  - mem_excp → flush=1, stall=0, cnt←0, go RUN; md_done not asserted.
  - cnt≠0 → stall=6'b001111, cnt←cnt−1; ex_md_req ignored; load-use not evaluated.
  - cnt==0 → stall=0, md_done=1, go RUN.
- Priority: exception > MULT/DIV > load-use.
- Register $0 never creates a hazard.

## Timing
- stall, flush, new_pc are combinational from state and inputs (same-cycle); md_done is a function of registered state only.
- Request at cycle t with occupancy N: stall high cycles t..t+N−1, md_done and stall=0 at t+N.
- N=1: one stall cycle, md_done at t+1.
- Load-use: exactly one bubble; stall drops next cycle once the load has left EX.
- Reset (rst=0, any time, including mid-MD_BUSY): state RUN, cnt 0, stall 0, flush 0, new_pc 0, md_done 0, perf counters 0.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cnt (32) — increments every cycle stall≠0 — and perf_flush_cnt (32) — increments every cycle flush=1; both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Shared package mips_defs: STALL_W=6, stall bit indices (STL_PC..STL_WB), stall constants STALL_NONE/STALL_LDUSE/STALL_MD, EXC_VECTOR default, pipe_ctrl state enum.
- One sub-module md_timer: loadable 6-bit down-counter with busy/zero outputs; FSM and hazard logic stay in pipe_ctrl.

## Test plan
- Load-use: EX lw $5, ID add reads rs=$5 → stall=6'b000111 one cycle, then 0; repeat with ex_wd_addr=0 → no stall.
- MULT: ex_md_req=1, ex_md_div=0, MULT_CYCLES=4 → stall=001111 cycles 0..3, md_done=1 at cycle 4, stall=0.
- DIV with concurrent load-use at cycle 0 → MULT/DIV stall wins; 34 stall cycles, md_done at cycle 34.
- mem_excp at cycle 10 of DIV → flush=1, new_pc=32'hBFC0_0380, stall=0 that cycle, no md_done afterward, RUN next cycle.
- rst low mid-MD_BUSY → all outputs 0 immediately; after release, new ex_md_req restarts full count.
- PIPE_CTRL_PERF_EN: one MULT (4) + one load-use + one flush → perf_stall_cnt=5, perf_flush_cnt=1.
